// File: rtl/received_num_tx_pkg.sv
// Shared constants for the received-number TX message: default field widths,
// the message identifier, the header overrun flag position and FSM encodings.
package received_num_tx_pkg;

    localparam int          RN_ADDR_WIDTH = 8;
    localparam int          RN_DATA_WIDTH = 32;
    localparam logic [7:0]  RN_MSG_ID     = 8'h02;
    localparam int          HDR_OVR_BIT   = 7;

    localparam logic [1:0]  ST_IDLE = 2'd0;
    localparam logic [1:0]  ST_ACK  = 2'd1;
    localparam logic [1:0]  ST_SEND = 2'd2;

    // Number of whole bytes needed to carry a field of the given bit width.
    function automatic int bytes_for(input int bits);
        return (bits + 7) / 8;
    endfunction

endpackage

// File: rtl/received_num_tx_byte_shift_out.sv
// Parallel-load, byte-shift-left register. The top byte is presented on
// out_byte_o; each shift moves the next byte up and fills zeros from below.
// Load has priority over shift. Reusable for any TX message type.
module received_num_tx_byte_shift_out #(
    parameter int NBYTES = 6
) (
    input  logic                  clk_i,
    input  logic                  n_reset_i,
    input  logic                  load_i,
    input  logic                  shift_i,
    input  logic [NBYTES*8-1:0]   load_data_i,
    output logic [7:0]            out_byte_o
);

    localparam int SW = NBYTES * 8;

    logic [SW-1:0] shreg_q;

    // Message shift register: load a full message or advance by one byte.
    always_ff @(posedge clk_i or negedge n_reset_i) begin
        if (!n_reset_i) begin
            shreg_q <= '0;
        end else if (load_i) begin
            shreg_q <= load_data_i;
        end else if (shift_i) begin
            shreg_q <= {shreg_q[SW-9:0], 8'h00};
        end else begin
            shreg_q <= shreg_q;
        end
    end

    assign out_byte_o = shreg_q[SW-1 -: 8];

endmodule

// File: rtl/received_num_tx.sv
// Reader end of the memory manager's received-number handshake. Each word
// {addr, data} is acknowledged and serialised MSB-first as
// header, address bytes, data bytes onto the UART TX byte interface.
module received_num_tx
    import received_num_tx_pkg::*;
#(
    parameter int         ADDR_WIDTH = RN_ADDR_WIDTH,
    parameter int         DATA_WIDTH = RN_DATA_WIDTH,
    parameter logic [7:0] MSG_ID     = RN_MSG_ID
) (
    input  logic                             clk,
    input  logic                             n_reset,
    input  logic                             run,
    input  logic [ADDR_WIDTH+DATA_WIDTH-1:0] mem_received_num,
    input  logic                             mem_valid,
    input  logic                             mem_overrun,
    output logic                             mem_ack,
    output logic [7:0]                       tx_data,
    output logic                             tx_valid,
    input  logic                             tx_ready,
    output logic                             busy,
    output logic                             overrun_seen
);

    localparam int AB     = bytes_for(ADDR_WIDTH);
    localparam int DB     = bytes_for(DATA_WIDTH);
    localparam int NBYTES = 1 + AB + DB;
    localparam int SW     = NBYTES * 8;
    localparam int CW     = $clog2(NBYTES + 1);

    localparam logic [CW-1:0] LAST_IDX = CW'(NBYTES - 1);

    logic [1:0]     state_q,    state_d;
    logic [CW-1:0]  cnt_q,      cnt_d;
    logic           mem_ack_q,  mem_ack_d;
    logic           tx_valid_q, tx_valid_d;
    logic           busy_q,     busy_d;
    logic           ovr_q,      ovr_d;

    logic           load_s;
    logic           shift_s;
    logic [AB*8-1:0] addr_ext_s;
    logic [DB*8-1:0] data_ext_s;
    logic [7:0]     hdr_s;
    logic [SW-1:0]  load_word_s;
    logic [7:0]     out_byte_s;

    // Build the full message: header with live overrun flag, zero-extended fields.
    always_comb begin
        addr_ext_s = '0;
        data_ext_s = '0;
        addr_ext_s[ADDR_WIDTH-1:0] = mem_received_num[ADDR_WIDTH+DATA_WIDTH-1 -: ADDR_WIDTH];
        data_ext_s[DATA_WIDTH-1:0] = mem_received_num[DATA_WIDTH-1:0];
        hdr_s = MSG_ID;
        hdr_s[HDR_OVR_BIT] = ovr_d;
        load_word_s = {hdr_s, addr_ext_s, data_ext_s};
    end

    // Next-state logic for the capture / acknowledge / send sequence.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        mem_ack_d  = 1'b0;
        tx_valid_d = tx_valid_q;
        busy_d     = busy_q;
        load_s     = 1'b0;
        shift_s    = 1'b0;
        // Overrun flag includes the current cycle so the header sees it.
        ovr_d      = ovr_q | mem_overrun;

        case (state_q)
            ST_IDLE: begin
                if (run && mem_valid) begin
                    load_s    = 1'b1;
                    mem_ack_d = 1'b1;
                    busy_d    = 1'b1;
                    state_d   = ST_ACK;
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_ACK: begin
                tx_valid_d = 1'b1;
                state_d    = ST_SEND;
            end
            ST_SEND: begin
                if (tx_valid_q && tx_ready) begin
                    shift_s = 1'b1;
                    if (cnt_q == LAST_IDX) begin
                        cnt_d      = '0;
                        tx_valid_d = 1'b0;
                        busy_d     = 1'b0;
                        state_d    = ST_IDLE;
                    end else begin
                        cnt_d      = cnt_q + CW'(1);
                    end
                end else begin
                    state_d = ST_SEND;
                end
            end
            default: begin
                cnt_d      = '0;
                tx_valid_d = 1'b0;
                busy_d     = 1'b0;
                state_d    = ST_IDLE;
            end
        endcase
    end

    // State, counter and registered handshake outputs.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            mem_ack_q  <= 1'b0;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            mem_ack_q  <= mem_ack_d;
            tx_valid_q <= tx_valid_d;
            busy_q     <= busy_d;
            ovr_q      <= ovr_d;
        end
    end

    received_num_tx_byte_shift_out #(
        .NBYTES (NBYTES)
    ) u_shift (
        .clk_i       (clk),
        .n_reset_i   (n_reset),
        .load_i      (load_s),
        .shift_i     (shift_s),
        .load_data_i (load_word_s),
        .out_byte_o  (out_byte_s)
    );

    assign mem_ack      = mem_ack_q;
    assign tx_valid     = tx_valid_q;
    assign tx_data      = out_byte_s;
    assign busy         = busy_q;
    assign overrun_seen = ovr_q;

endmodule

// File: tb/tb_received_num_tx.sv
// Directed bench for received_num_tx: upstream word source, byte collector,
// and hand-computed expected byte sequences.
module tb_received_num_tx;

    logic        clk;
    logic        n_reset;
    logic        run;
    logic [39:0] mem_received_num;
    logic        mem_valid;
    logic        mem_overrun;
    logic        mem_ack;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        busy;
    logic        overrun_seen;

    int          checks;
    int          errors;
    int          ack_count;
    int          tv_count;
    logic        pend;
    logic        rdy_mode;
    logic        rdy_level;
    int          rdy_cyc;
    logic        stall_prev;
    logic [7:0]  data_prev;
    logic [7:0]  rx_q[$];
    logic [3:0]  rdy_pat;

    received_num_tx dut (
        .clk              (clk),
        .n_reset          (n_reset),
        .run              (run),
        .mem_received_num (mem_received_num),
        .mem_valid        (mem_valid),
        .mem_overrun      (mem_overrun),
        .mem_ack          (mem_ack),
        .tx_data          (tx_data),
        .tx_valid         (tx_valid),
        .tx_ready         (tx_ready),
        .busy             (busy),
        .overrun_seen     (overrun_seen)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Upstream drops valid combinationally while acking.
    assign mem_valid = pend && !mem_ack;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Byte collector, ack counter and stall-stability monitor.
    always @(negedge clk) begin
        if (mem_ack) begin
            ack_count++;
            pend = 1'b0;
        end
        if (tx_valid) tv_count++;
        if (stall_prev && tx_valid) check_eq("stall_stable", {56'd0, tx_data}, {56'd0, data_prev});
        if (tx_valid && tx_ready) rx_q.push_back(tx_data);
        stall_prev = tx_valid && !tx_ready;
        data_prev  = tx_data;
    end

    // tx_ready driver: fixed level or repeating 1,0,0,1 pattern.
    always @(posedge clk) begin
        #1;
        if (rdy_mode) begin
            tx_ready = rdy_pat[rdy_cyc % 4];
            rdy_cyc++;
        end else begin
            tx_ready = rdy_level;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [7:0] a, input logic [31:0] d);
        tick();
        mem_received_num = {a, d};
        pend = 1'b1;
    endtask

    task automatic wait_idle(input string tag);
        logic done;
        done = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            #1;
            if (!busy && !pend) begin
                done = 1'b1;
                break;
            end
        end
        check_eq(tag, {63'd0, done}, 64'd1);
    endtask

    task automatic check_msg(input string tag, input int base, input logic [47:0] exp);
        logic [47:0] got;
        got = '0;
        for (int i = 0; i < 6; i++) begin
            if (base + i < rx_q.size()) got[47-8*i -: 8] = rx_q[base + i];
        end
        check_eq(tag, {16'd0, got}, {16'd0, exp});
    endtask

    initial begin
        int acks0;
        int tv0;
        logic seen;
        checks = 0; errors = 0; ack_count = 0; tv_count = 0;
        pend = 1'b0; stall_prev = 1'b0; data_prev = 8'h00;
        rdy_mode = 1'b0; rdy_level = 1'b1; rdy_cyc = 0; rdy_pat = 4'b1001;
        tx_ready = 1'b1; run = 1'b1; mem_overrun = 1'b0;
        mem_received_num = 40'd0;
        n_reset = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_ack",   {63'd0, mem_ack},      64'd0);
        check_eq("rst_valid", {63'd0, tx_valid},     64'd0);
        check_eq("rst_data",  {56'd0, tx_data},      64'd0);
        check_eq("rst_busy",  {63'd0, busy},         64'd0);
        check_eq("rst_ovr",   {63'd0, overrun_seen}, 64'd0);
        tick();
        n_reset = 1'b1;

        // Basic message with exact ack / first-byte timing
        rx_q.delete(); ack_count = 0;
        present(8'h05, 32'hDEADBEEF);
        @(negedge clk);
        check_eq("ack_early", {63'd0, mem_ack}, 64'd0);
        @(negedge clk);
        check_eq("ack_pulse", {63'd0, mem_ack}, 64'd1);
        @(negedge clk);
        check_eq("ack_single", {63'd0, mem_ack},  64'd0);
        check_eq("hdr_valid",  {63'd0, tx_valid}, 64'd1);
        check_eq("hdr_byte",   {56'd0, tx_data},  64'h02);
        check_eq("busy_send",  {63'd0, busy},     64'd1);
        wait_idle("basic_done");
        check_msg("basic_msg", 0, 48'h0205DEADBEEF);
        check_eq("basic_len",  rx_q.size(), 64'd6);
        check_eq("basic_acks", ack_count,   64'd1);
        check_eq("basic_idle_valid", {63'd0, tx_valid}, 64'd0);

        // Backpressure with ready pattern 1,0,0,1
        rx_q.delete(); ack_count = 0;
        rdy_cyc = 0; rdy_mode = 1'b1;
        present(8'h05, 32'hDEADBEEF);
        wait_idle("bp_done");
        check_msg("bp_msg", 0, 48'h0205DEADBEEF);
        check_eq("bp_len",  rx_q.size(), 64'd6);
        check_eq("bp_acks", ack_count,   64'd1);
        rdy_mode = 1'b0;

        // Word presented while busy is held off until IDLE
        rx_q.delete(); ack_count = 0;
        present(8'h05, 32'hDEADBEEF);
        for (int i = 0; i < 50 && pend; i++) @(negedge clk);
        present(8'h02, 32'h11223344);
        for (int i = 0; i < 50 && rx_q.size() < 6; i++) @(negedge clk);
        check_eq("busy_noack", ack_count, 64'd1);
        wait_idle("busy_done");
        check_msg("busy_msg1", 0, 48'h0205DEADBEEF);
        check_msg("busy_msg2", 6, 48'h020211223344);
        check_eq("busy_acks", ack_count, 64'd2);

        // run gating in IDLE
        rx_q.delete(); ack_count = 0;
        tick();
        run = 1'b0;
        acks0 = ack_count; tv0 = tv_count;
        present(8'h07, 32'h01020304);
        repeat (10) @(negedge clk);
        check_eq("run0_noack",  ack_count, acks0);
        check_eq("run0_novalid", tv_count, tv0);
        // run released, then dropped mid-message
        tick();
        run = 1'b1;
        for (int i = 0; i < 50 && rx_q.size() < 2; i++) @(negedge clk);
        tick();
        run = 1'b0;
        wait_idle("run_drop_done");
        check_msg("run_drop_msg", 0, 48'h020701020304);
        check_eq("run_drop_acks", ack_count, 64'd1);
        tick();
        run = 1'b1;

        // Reset mid-message
        rx_q.delete(); ack_count = 0;
        present(8'h09, 32'hCAFEF00D);
        for (int i = 0; i < 50 && rx_q.size() < 3; i++) @(negedge clk);
        tick();
        n_reset = 1'b0;
        #1;
        check_eq("rstmid_valid", {63'd0, tx_valid}, 64'd0);
        check_eq("rstmid_busy",  {63'd0, busy},     64'd0);
        tick();
        n_reset = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("rstmid_quiet", {63'd0, tx_valid}, 64'd0);
        check_eq("rstmid_ovr",   {63'd0, overrun_seen}, 64'd0);

        // Overrun flag sets header bit 7 and stays sticky
        rx_q.delete(); ack_count = 0;
        tick();
        mem_overrun = 1'b1;
        tick();
        mem_overrun = 1'b0;
        @(negedge clk);
        check_eq("ovr_set", {63'd0, overrun_seen}, 64'd1);
        present(8'h01, 32'h00000007);
        wait_idle("ovr_done");
        check_msg("ovr_msg", 0, 48'h820100000007);
        check_eq("ovr_len", rx_q.size(), 64'd6);
        rx_q.delete();
        present(8'h03, 32'h0000ABCD);
        wait_idle("ovr2_done");
        check_msg("ovr2_msg", 0, 48'h82030000ABCD);
        check_eq("ovr_sticky", {63'd0, overrun_seen}, 64'd1);

        seen = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
